// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - EX-side request, divider handshake and HI/LO bus for div_issue_ctrl
interface div_issue_ctrl_if;
    logic        start;
    logic        sign;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        stall;
    logic        div_valid;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_out_valid;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        timeout_err;

    // controller side
    modport slave (
        input  start, sign, srca, srcb, flush, mthi, mtlo, wdata,
        input  div_out_valid, div_hi, div_lo,
        output stall, div_valid, div_sign, div_a, div_b, hi, lo, timeout_err
    );

    // pipeline / divider / environment side
    modport master (
        output start, sign, srca, srcb, flush, mthi, mtlo, wdata,
        output div_out_valid, div_hi, div_lo,
        input  stall, div_valid, div_sign, div_a, div_b, hi, lo, timeout_err
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - divide issue FSM with architectural HI/LO ownership
module div_issue_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    div_issue_ctrl_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     div_a_q, div_a_d;
    logic [31:0]     div_b_q, div_b_d;
    logic            div_sign_q, div_sign_d;

    logic            stall;
    logic            div_valid;
    logic            timeout_err;
    logic            res_we;
    logic            latch_ops;
    logic            timed_out;
    logic            mt_ok;

    assign timed_out = (cnt_q == CW'(TIMEOUT));

    // Next-state, handshake outputs and the WAIT/DRAIN watchdog counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        stall       = 1'b0;
        div_valid   = 1'b0;
        timeout_err = 1'b0;
        res_we      = 1'b0;
        latch_ops   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    latch_ops = 1'b1;
                    stall     = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // the request has gone to the divider even if flushed now
                div_valid = 1'b1;
                stall     = 1'b1;
                state_d   = bus.flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (timed_out) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end else if (bus.div_out_valid) begin
                    if (bus.flush) begin
                        state_d = S_IDLE;
                    end else begin
                        res_we  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (bus.flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                // start here is the retiring divide itself, not a new one
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                stall = bus.start;
                if (timed_out) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end else if (bus.div_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_WAIT || state_d == S_DRAIN) begin
            cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;
        end
    end

    assign mt_ok = !stall && !bus.flush;

    // HI/LO and operand next values; operands only change on acceptance in IDLE
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        div_sign_d = div_sign_q;
        if (res_we) begin
            hi_d = bus.div_hi;
            lo_d = bus.div_lo;
        end else if (mt_ok) begin
            if (bus.mthi) hi_d = bus.wdata;
            if (bus.mtlo) lo_d = bus.wdata;
        end
        if (latch_ops) begin
            div_a_d    = bus.srca;
            div_b_d    = bus.srcb;
            div_sign_d = bus.sign;
        end
    end

    // State, counter and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            div_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            div_sign_q <= div_sign_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.div_valid   = div_valid;
    assign bus.div_sign    = div_sign_q;
    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;
    localparam int LAT = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // divider model: fixed latency LAT, not affected by rst, can be muted
    logic        resp_en;
    int          rem;
    logic [31:0] pend_q, pend_r;
    initial begin
        rem               = 0;
        bus.div_out_valid = 1'b0;
        bus.div_hi        = '0;
        bus.div_lo        = '0;
    end
    always @(posedge clk) begin
        bus.div_out_valid <= 1'b0;
        if (rem == 1) begin
            bus.div_out_valid <= 1'b1;
            bus.div_lo        <= pend_q;
            bus.div_hi        <= pend_r;
        end
        if (rem > 0) rem <= rem - 1;
        if (bus.div_valid && resp_en) begin
            rem <= LAT - 1;
            if (bus.div_b == 32'd0) begin
                pend_q <= '1;
                pend_r <= bus.div_a;
            end else if (bus.div_sign) begin
                pend_q <= $signed(bus.div_a) / $signed(bus.div_b);
                pend_r <= $signed(bus.div_a) % $signed(bus.div_b);
            end else begin
                pend_q <= bus.div_a / bus.div_b;
                pend_r <= bus.div_a % bus.div_b;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one full divide from IDLE; returns in the DONE cycle (cycle 2+LAT)
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int stall_lo;
        int sign_bad;
        stall_lo = 0;
        sign_bad = 0;
        cyc();
        bus.start = 1'b1; bus.sign = s; bus.srca = a; bus.srcb = b;
        #2;
        check_eq("c0_stall", {31'd0, bus.stall}, 32'd1);
        cyc();
        bus.start = 1'b0;
        #2;
        check_eq("c1_div_valid", {31'd0, bus.div_valid}, 32'd1);
        check_eq("c1_div_a", bus.div_a, a);
        check_eq("c1_div_b", bus.div_b, b);
        for (int c = 2; c <= LAT + 1; c++) begin
            cyc();
            #2;
            if (!bus.stall) stall_lo++;
            if (bus.div_sign !== s || bus.div_valid !== 1'b0) sign_bad++;
        end
        check_eq("wait_stall_low_cycles", stall_lo, 0);
        check_eq("wait_sign_or_valid_bad", sign_bad, 0);
        cyc();
        #2;
        check_eq("done_stall", {31'd0, bus.stall}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resp_en  = 1'b1;
        rst      = 1'b1;
        bus.start = 1'b0; bus.sign = 1'b0; bus.srca = '0; bus.srcb = '0;
        bus.flush = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;

        #12;
        check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("rst_div_valid", {31'd0, bus.div_valid}, 32'd0);
        check_eq("rst_div_sign", {31'd0, bus.div_sign}, 32'd0);
        check_eq("rst_div_a", bus.div_a, 32'd0);
        check_eq("rst_div_b", bus.div_b, 32'd0);
        check_eq("rst_hi", bus.hi, 32'd0);
        check_eq("rst_lo", bus.lo, 32'd0);
        check_eq("rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // unsigned 100/7
        do_div(1'b0, 32'd100, 32'd7);
        check_eq("udiv_lo", bus.lo, 32'd14);
        check_eq("udiv_hi", bus.hi, 32'd2);

        // signed -7/2
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        check_eq("sdiv_lo", bus.lo, 32'hFFFF_FFFD);
        check_eq("sdiv_hi", bus.hi, 32'hFFFF_FFFF);

        // MTHI then MTLO, then preload 0x11/0x22
        cyc(); bus.mthi = 1'b1; bus.wdata = 32'hAAAA_5555;
        cyc(); bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h1234_5678;
        cyc(); bus.mtlo = 1'b0;
        #2;
        check_eq("mthi_val", bus.hi, 32'hAAAA_5555);
        check_eq("mtlo_val", bus.lo, 32'h1234_5678);
        cyc(); bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0000_0077;
        cyc(); bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.flush = 1'b1; bus.wdata = 32'h0000_0099;
        bus.mthi = 1'b1;
        cyc(); bus.flush = 1'b0; bus.mthi = 1'b1; bus.wdata = 32'h11;
        cyc(); bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h22;
        #2;
        check_eq("mt_both_lo", bus.lo, 32'h77);
        check_eq("mt_flushed_hi_then_11", bus.hi, 32'h11);

        // flush in WAIT at cycle 4, start held from cycle 6
        cyc(); bus.mtlo = 1'b0;
        bus.start = 1'b1; bus.sign = 1'b0; bus.srca = 32'd50; bus.srcb = 32'd5;
        cyc(); bus.start = 1'b0;
        cyc();
        cyc();
        cyc(); bus.flush = 1'b1;
        #2;
        check_eq("fl_c4_stall", {31'd0, bus.stall}, 32'd1);
        cyc(); bus.flush = 1'b0;
        #2;
        check_eq("fl_c5_stall", {31'd0, bus.stall}, 32'd0);
        cyc(); bus.start = 1'b1; bus.srca = 32'd9; bus.srcb = 32'd4;
        #2;
        check_eq("fl_c6_stall", {31'd0, bus.stall}, 32'd1);
        for (int c = 7; c <= 9; c++) begin
            cyc();
            #2;
            check_eq("fl_drain_stall", {31'd0, bus.stall}, 32'd1);
        end
        cyc();
        #2;
        check_eq("fl_c10_stall", {31'd0, bus.stall}, 32'd1);
        check_eq("fl_c10_div_valid", {31'd0, bus.div_valid}, 32'd0);
        check_eq("fl_c10_hi", bus.hi, 32'h11);
        check_eq("fl_c10_lo", bus.lo, 32'h22);
        cyc(); bus.start = 1'b0;
        #2;
        check_eq("fl_c11_div_valid", {31'd0, bus.div_valid}, 32'd1);
        check_eq("fl_c11_div_a", bus.div_a, 32'd9);
        cyc(); bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        cyc(); bus.mthi = 1'b0;
        #2;
        check_eq("mthi_in_wait", bus.hi, 32'h11);
        for (int c = 14; c <= 20; c++) cyc();
        #2;
        check_eq("fl2_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("fl2_lo", bus.lo, 32'd2);
        check_eq("fl2_hi", bus.hi, 32'd1);

        // timeout with a silent divider
        resp_en = 1'b0;
        cyc(); bus.start = 1'b1; bus.srca = 32'd33; bus.srcb = 32'd3;
        cyc(); bus.start = 1'b0;
        for (int c = 2; c <= 17; c++) begin
            cyc();
            #2;
            if (c == 17) check_eq("to_c17_err", {31'd0, bus.timeout_err}, 32'd0);
        end
        cyc();
        #2;
        check_eq("to_c18_err", {31'd0, bus.timeout_err}, 32'd1);
        check_eq("to_c18_stall", {31'd0, bus.stall}, 32'd1);
        cyc();
        #2;
        check_eq("to_c19_err", {31'd0, bus.timeout_err}, 32'd0);
        check_eq("to_c19_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("to_hi", bus.hi, 32'd1);
        check_eq("to_lo", bus.lo, 32'd2);
        resp_en = 1'b1;

        // async reset mid-WAIT, then a stray result
        cyc(); bus.start = 1'b1; bus.srca = 32'd100; bus.srcb = 32'd7;
        cyc(); bus.start = 1'b0;
        cyc();
        cyc();
        cyc();
        #2;
        check_eq("ar_wait_stall", {31'd0, bus.stall}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("ar_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("ar_div_a", bus.div_a, 32'd0);
        check_eq("ar_div_b", bus.div_b, 32'd0);
        check_eq("ar_hi", bus.hi, 32'd0);
        check_eq("ar_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 5; c <= 11; c++) cyc();
        #2;
        check_eq("ar_late_hi", bus.hi, 32'd0);
        check_eq("ar_late_lo", bus.lo, 32'd0);
        check_eq("ar_late_stall", {31'd0, bus.stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Division issue and HI/LO control stage that sits directly upstream of the divider IP wrapper. It accepts a divide request from the EX stage and latches the operands and signedness. It launches one operation into the divider, stalls the pipeline until the result returns, and commits the quotient to LO and the remainder to HI. It also owns the architectural HI/LO registers (MTHI/MTLO writes) and discards results of flushed divides.

## Interface
- TIMEOUT, 64: maximum cycles spent in WAIT or DRAIN before the operation is abandoned.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  EX requests a divide (DIV/DIVU)
- sign  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
- srca  in  32  dividend
- srcb  in  32  divisor
- flush  in  1  exception/redirect; cancels the in-flight divide
- mthi, mtlo  in  1  write HI / LO from wdata
- wdata  in  32  MTHI/MTLO data
- stall  out  1  hold EX and earlier stages
- div_valid  out  1  in_valid to divider, one-cycle pulse
- div_sign  out  1  sign to divider, registered
- div_a, div_b  out  32  registered operands to divider
- div_out_valid  in  1  divider result valid
- div_hi, div_lo  in  32  divider remainder / quotient
- hi, lo  out  32  architectural HI/LO
- timeout_err  out  1  one-cycle pulse on abandoned operation

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE
  - start=1 and flush=0: latch sign/srca/srcb into div_sign/div_a/div_b, go to ISSUE.
  - start with flush=1 is ignored.
- ISSUE
  - div_valid=1 for exactly this cycle.
  - Next state is WAIT, or DRAIN if flush=1. The issue is not retracted on flush.
- WAIT
  - On div_out_valid: lo<=div_lo, hi<=div_hi, go to DONE.
  - On flush without div_out_valid: go to DRAIN.
  - Flush and div_out_valid in the same cycle: result discarded, go to IDLE.
- DONE
  - stall=0 for one cycle so the divide instruction retires.
  - start seen in DONE belongs to the retiring instruction and is ignored. Go to IDLE.
- DRAIN
  - The divider cannot be cancelled, so this state waits for div_out_valid, drops the result, and returns to IDLE.
  - stall=0 unless start=1.
  - A new start is held off until IDLE.
- div_sign, div_a and div_b stay constant from ISSUE until the result or drain completes. The divider wrapper selects its output by sign, so div_sign must be stable.
- stall = (IDLE & start & ~flush) | ISSUE | WAIT | (DRAIN & start).
- MTHI/MTLO
  - Written only when stall=0 (IDLE, DONE, or DRAIN without start).
  - Ignored if flush=1 in the same cycle.
  - Same-cycle mthi and mtlo write both registers.
- Timeout
  - A counter of width $clog2(TIMEOUT+1) clears on entering WAIT/DRAIN and increments each cycle there.
  - When it reaches TIMEOUT: pulse timeout_err, go to IDLE, leave HI/LO unchanged.
- Divide by zero is issued normally. HI/LO take whatever the divider returns (architecturally undefined).

## Timing
- Reset values: state IDLE, hi=lo=0, div_a=div_b=0, div_sign=0, div_valid=0, stall=0, timeout_err=0, counter=0.
- Reset mid-operation returns to IDLE immediately. Any later stray div_out_valid in IDLE is ignored.
- Let divider latency be L: out_valid arrives L cycles after in_valid.
  - Cycle 0: start in IDLE, stall=1.
  - Cycle 1: ISSUE.
  - Cycle 1+L: div_out_valid, HI/LO updated at the end of this cycle.
  - Cycle 2+L: DONE, stall=0.
- Total stall cycles = 2+L.
- New hi/lo are visible on the outputs from cycle 2+L.
- Back-to-back divides: the second start is accepted at cycle 3+L.

## Test plan
- Unsigned: start, sign=0, srca=100, srcb=7, L=8 -> one div_valid pulse at cycle 1; stall high cycles 0-9; lo=14, hi=2 at cycle 10.
- Signed: sign=1, srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div_sign stays 1 throughout WAIT.
- Flush in WAIT at cycle 4 (prior hi=0x11, lo=0x22) -> stall drops at cycle 5; result at cycle 9 discarded; hi/lo stay 0x11/0x22. A start at cycle 6 stays stalled until cycle 10, then issues.
- MTHI then MTLO in consecutive IDLE cycles with wdata 0xAAAA5555, 0x12345678 -> hi=0xAAAA5555, lo=0x12345678. An mthi during WAIT has no effect.
- Timeout: TIMEOUT=16, divider model never responds -> timeout_err pulses 16 cycles after entering WAIT; state returns to IDLE; hi/lo unchanged.
- Async rst asserted mid-WAIT between clock edges -> outputs at reset values immediately. A late div_out_valid after reset release leaves hi=lo=0.
